// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - gpio_in register map and CPU memory-map base
package gpio_pkg;

  localparam logic [31:0] GPIO_IN_BASE = 32'h4000_1000;

  localparam logic [1:0] ADDR_VALUE = 2'd0;
  localparam logic [1:0] ADDR_RISE  = 2'd1;
  localparam logic [1:0] ADDR_FALL  = 2'd2;
  localparam logic [1:0] ADDR_MASK  = 2'd3;

endpackage

// File: rtl/gpio_sync.sv
// rtl/gpio_sync.sv - per-bit 2-flop synchronizer for asynchronous pins
module gpio_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/gpio_in.sv
// rtl/gpio_in.sv - GPIO input block: sync, VALUE, W1C RISE/FALL, MASK, irq
// Optional debounce filter enabled by macro GPIO_IN_DEBOUNCE_EN.
module gpio_in
  import gpio_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int DEBOUNCE_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  input  logic [1:0]       addr,
  input  logic             re,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_nxt;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] rise_clr;
  logic [WIDTH-1:0] fall_clr;

  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pins),
    .q     (sync_q)
  );

`ifdef GPIO_IN_DEBOUNCE_EN
  logic [DEBOUNCE_LOG2-1:0] tick_cnt;
  logic [WIDTH-1:0]         samp_q;
  logic                     tick;
  logic [WIDTH-1:0]         agree;

  assign tick  = &tick_cnt;
  assign agree = ~(sync_q ^ samp_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      samp_q   <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      if (tick) samp_q <= sync_q;
    end
  end

  // A bit moves only when this sample matches the previous one.
  always_comb begin
    value_nxt = value_q;
    if (tick) value_nxt = (agree & sync_q) | (~agree & value_q);
  end
`else
  assign value_nxt = sync_q;
`endif

  always_comb begin
    rise_clr = '0;
    fall_clr = '0;
    if (we && addr == ADDR_RISE) rise_clr = wdata;
    if (we && addr == ADDR_FALL) fall_clr = wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      mask_q  <= '0;
      irq     <= 1'b0;
      rdata   <= '0;
    end else begin
      value_q <= value_nxt;
      // New edges are OR-ed in after the clear so a coincident event survives.
      rise_q  <= (rise_q & ~rise_clr) | (value_nxt & ~value_q);
      fall_q  <= (fall_q & ~fall_clr) | (~value_nxt & value_q);
      if (we && addr == ADDR_MASK) mask_q <= wdata;
      irq <= |((rise_q | fall_q) & mask_q);
      if (re) begin
        unique case (addr)
          ADDR_VALUE: rdata <= value_q;
          ADDR_RISE:  rdata <= rise_q;
          ADDR_FALL:  rdata <= fall_q;
          ADDR_MASK:  rdata <= mask_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_in.sv
// tb/tb_gpio_in.sv - scoreboard bench for gpio_in
module tb_gpio_in;
  import gpio_pkg::*;

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int LAT = 3 + 2 * (1 << 4);
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pins;
  logic [1:0]  addr;
  logic        re;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_inflight = 1'b0;

  gpio_in #(.WIDTH(32), .DEBOUNCE_LOG2(4)) dut (
    .clk   (clk),
    .reset (reset),
    .pins  (pins),
    .addr  (addr),
    .re    (re),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) rd_inflight <= re & reset;

  always @(negedge clk) begin
    if (rd_inflight) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk(tag_q.pop_front(), rdata, exp_q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string t);
    addr = a; re = 1'b1;
    exp_q.push_back(e); tag_q.push_back(t);
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; we = 1'b1; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b0; pins = 32'hFFFF_FFFF; addr = '0; re = 1'b0; we = 1'b0; wdata = '0;
    idle(3);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b1;
`ifndef GPIO_IN_DEBOUNCE_EN
    rd(ADDR_VALUE, 32'h0, "value_c1");
    rd(ADDR_VALUE, 32'h0, "value_c2");
    rd(ADDR_VALUE, 32'h0, "value_c3");
    rd(ADDR_VALUE, 32'hFFFF_FFFF, "value_c4");
`else
    idle(LAT + 2);
    rd(ADDR_VALUE, 32'hFFFF_FFFF, "value_rel");
`endif
    rd(ADDR_RISE, 32'hFFFF_FFFF, "rise_first");
    rd(ADDR_FALL, 32'h0, "fall_first");
    chk("irq_unmasked", {31'b0, irq}, 32'h0);

    pins = 32'h0; idle(LAT + 2);
    wr(ADDR_RISE, 32'hFFFF_FFFF); wr(ADDR_FALL, 32'hFFFF_FFFF); wr(ADDR_MASK, 32'h1);
    pins = 32'h1;
`ifndef GPIO_IN_DEBOUNCE_EN
    idle(3);
    chk("irq_early", {31'b0, irq}, 32'h0);
    idle(1);
`else
    idle(LAT + 2);
`endif
    chk("irq_set", {31'b0, irq}, 32'h1);
    rd(ADDR_RISE, 32'h1, "rise_bit0");
    wr(ADDR_RISE, 32'h1);
    chk("irq_hold", {31'b0, irq}, 32'h1);
    idle(1);
    chk("irq_clr", {31'b0, irq}, 32'h0);
    rd(ADDR_RISE, 32'h0, "rise_w1c");

    pins = 32'hFF; idle(LAT + 2);
    wr(ADDR_RISE, 32'hFFFF_FFFF); wr(ADDR_FALL, 32'hFFFF_FFFF);
    pins = 32'h0F; idle(LAT + 2);
    rd(ADDR_FALL, 32'hF0, "fall_f0");
    rd(ADDR_RISE, 32'h0, "rise_unch");
    chk("irq_fall_masked", {31'b0, irq}, 32'h0);

    addr = ADDR_MASK; re = 1'b1; we = 1'b1; wdata = 32'hA5;
    exp_q.push_back(32'h1); tag_q.push_back("mask_rw_old");
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    rd(ADDR_MASK, 32'hA5, "mask_new");
    wr(ADDR_VALUE, 32'hFFFF_FFFF);
    rd(ADDR_VALUE, 32'h0F, "value_ro");
    chk("irq_fall_unmasked", {31'b0, irq}, 32'h1);

`ifndef GPIO_IN_DEBOUNCE_EN
    pins = 32'h07; idle(LAT + 2);
    wr(ADDR_RISE, 32'hFFFF_FFFF); wr(ADDR_FALL, 32'hFFFF_FFFF);
    pins = 32'h0F; idle(2);
    wr(ADDR_RISE, 32'h8);
    rd(ADDR_RISE, 32'h8, "set_wins");
    pins = 32'h07; idle(LAT + 2);
    wr(ADDR_FALL, 32'hFFFF_FFF0 & ~32'h8);
    rd(ADDR_FALL, 32'h8, "w1c_zero_bits");
`else
    wr(ADDR_RISE, 32'hFFFF_FFFF); wr(ADDR_FALL, 32'hFFFF_FFFF);
    pins = 32'h8F; idle(5);
    pins = 32'h0F; idle(LAT + 5);
    rd(ADDR_VALUE, 32'h0F, "glitch_value");
    rd(ADDR_RISE, 32'h0, "glitch_rise");
    rd(ADDR_FALL, 32'h0, "glitch_fall");
    pins = 32'h8F; idle(40);
    pins = 32'h0F; idle(LAT + 5);
    rd(ADDR_RISE, 32'h80, "pulse_rise");
    rd(ADDR_FALL, 32'h80, "pulse_fall");
`endif

    pins = 32'h0; idle(LAT + 2);
    wr(ADDR_RISE, 32'hFFFF_FFFF); wr(ADDR_FALL, 32'hFFFF_FFFF); wr(ADDR_MASK, 32'hFFFF_FFFF);
    pins = 32'h0000_FFFF; idle(LAT + 2);
    rd(ADDR_RISE, 32'h0000_FFFF, "rise_ffff");
    chk("irq_pre_rst", {31'b0, irq}, 32'h1);
    idle(2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_irq", {31'b0, irq}, 32'h0);
    chk("async_rdata", rdata, 32'h0);
    chk("async_rise", dut.rise_q, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idle(LAT + 2);
    rd(ADDR_RISE, 32'h0000_FFFF, "rise_after_rst");
    rd(ADDR_MASK, 32'h0, "mask_after_rst");

    idle(2);
    chk("sb_empty", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
